// File: rtl/hazard_ctrl.sv
// Hazard and forwarding sequencer for the decode -> regFile -> alu_stage pipeline.
// Tracks EX/MEM/WB destination tags (p0/p1/p2), raises load-use stalls and selects forwards.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_regA,
  input  logic [REG_ADDR_W-1:0] dec_regB,
  input  logic                  dec_useA,
  input  logic                  dec_useB,
  input  logic [REG_ADDR_W-1:0] dec_regD,
  input  logic                  dec_writes,
  input  logic                  dec_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            fwdA_sel,
  output logic [1:0]            fwdB_sel,
  output logic                  ex_valid,
  output logic                  wb_wrt_en,
  output logic [REG_ADDR_W-1:0] wb_addrD,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  function automatic logic hit(input logic vld, input logic wr,
                               input logic [REG_ADDR_W-1:0] rd,
                               input logic [REG_ADDR_W-1:0] src,
                               input logic use_src);
    return vld & wr & (rd == src) & (src != '0) & use_src;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic en);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (en && (cnt != {CNT_W{1'b1}}))
      nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    return nxt;
  endfunction

  logic                  vld_p0_q, wr_p0_q, ld_p0_q;
  logic [REG_ADDR_W-1:0] rd_p0_q;
  logic                  vld_p1_q, wr_p1_q;
  logic [REG_ADDR_W-1:0] rd_p1_q;
  logic                  vld_p2_q, wr_p2_q;
  logic [REG_ADDR_W-1:0] rd_p2_q;
  logic [1:0]            fwdA_q, fwdB_q, fwdA_d, fwdB_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic                  hitA_ex, hitB_ex, hitA_mem, hitB_mem;
  logic                  stall_d, load_ex;

  // Decode-stage hazard detection against EX (p0) and MEM (p1)
  always_comb begin
    hitA_ex  = hit(vld_p0_q, wr_p0_q, rd_p0_q, dec_regA, dec_useA);
    hitB_ex  = hit(vld_p0_q, wr_p0_q, rd_p0_q, dec_regB, dec_useB);
    hitA_mem = hit(vld_p1_q, wr_p1_q, rd_p1_q, dec_regA, dec_useA);
    hitB_mem = hit(vld_p1_q, wr_p1_q, rd_p1_q, dec_regB, dec_useB);
    stall_d  = dec_valid & ~flush & ld_p0_q & (hitA_ex | hitB_ex);
    load_ex  = dec_valid & ~flush & ~stall_d;
    fwdA_d   = SEL_RF;
    fwdB_d   = SEL_RF;
    if (load_ex) begin
      if (hitA_ex & ~ld_p0_q) fwdA_d = SEL_MEM;
      else if (hitA_mem)      fwdA_d = SEL_WB;
      if (hitB_ex & ~ld_p0_q) fwdB_d = SEL_MEM;
      else if (hitB_mem)      fwdB_d = SEL_WB;
    end
    stall_cnt_d = sat_inc(stall_cnt_q, stall_d);
    fwd_cnt_d   = sat_inc(fwd_cnt_q, (fwdA_d != SEL_RF) | (fwdB_d != SEL_RF));
  end

  // Stage boundary: decode -> EX -> MEM -> WB tag shift
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0_q    <= 1'b0;
      wr_p0_q     <= 1'b0;
      ld_p0_q     <= 1'b0;
      rd_p0_q     <= '0;
      vld_p1_q    <= 1'b0;
      wr_p1_q     <= 1'b0;
      rd_p1_q     <= '0;
      vld_p2_q    <= 1'b0;
      wr_p2_q     <= 1'b0;
      rd_p2_q     <= '0;
      fwdA_q      <= SEL_RF;
      fwdB_q      <= SEL_RF;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      vld_p0_q    <= load_ex;
      wr_p0_q     <= load_ex & dec_writes;
      ld_p0_q     <= load_ex & dec_is_load;
      rd_p0_q     <= load_ex ? dec_regD : '0;
      vld_p1_q    <= vld_p0_q & ~flush;
      wr_p1_q     <= wr_p0_q & ~flush;
      rd_p1_q     <= rd_p0_q;
      vld_p2_q    <= vld_p1_q;
      wr_p2_q     <= wr_p1_q;
      rd_p2_q     <= rd_p1_q;
      fwdA_q      <= fwdA_d;
      fwdB_q      <= fwdB_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall     = stall_d;
  assign fwdA_sel  = fwdA_q;
  assign fwdB_sel  = fwdB_q;
  assign ex_valid  = vld_p0_q;
  assign wb_wrt_en = vld_p2_q & wr_p2_q & (rd_p2_q != '0);
  assign wb_addrD  = rd_p2_q;
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed instruction stream, EX and WB monitors.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_useA, dec_useB, dec_writes, dec_is_load, flush;
  logic [4:0] dec_regA, dec_regB, dec_regD;
  logic       stall, ex_valid, wb_wrt_en;
  logic [1:0] fwdA_sel, fwdB_sel;
  logic [4:0] wb_addrD;
  logic [15:0] stall_cnt, fwd_cnt;
  logic       s_stall, s_ex_valid, s_wb_wrt_en;
  logic [1:0] s_fwdA_sel, s_fwdB_sel;
  logic [4:0] s_wb_addrD;
  logic [3:0] s_stall_cnt, s_fwd_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] exq[$];
  logic [4:0] wbq[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_regA(dec_regA),
    .dec_regB(dec_regB), .dec_useA(dec_useA), .dec_useB(dec_useB),
    .dec_regD(dec_regD), .dec_writes(dec_writes), .dec_is_load(dec_is_load),
    .flush(flush), .stall(stall), .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
    .ex_valid(ex_valid), .wb_wrt_en(wb_wrt_en), .wb_addrD(wb_addrD),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt));

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_regA(dec_regA),
    .dec_regB(dec_regB), .dec_useA(dec_useA), .dec_useB(dec_useB),
    .dec_regD(dec_regD), .dec_writes(dec_writes), .dec_is_load(dec_is_load),
    .flush(flush), .stall(s_stall), .fwdA_sel(s_fwdA_sel), .fwdB_sel(s_fwdB_sel),
    .ex_valid(s_ex_valid), .wb_wrt_en(s_wb_wrt_en), .wb_addrD(s_wb_addrD),
    .stall_cnt(s_stall_cnt), .fwd_cnt(s_fwd_cnt));

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // EX and WB monitors: pop the expected entry whenever the DUT presents one
  always @(negedge clk) begin
    if (!reset) begin
      if (ex_valid) begin
        if (exq.size() == 0) chk("ex_unexpected", 1, 0);
        else chk("fwd_sel", int'({fwdA_sel, fwdB_sel}), int'(exq.pop_front()));
      end
      if (wb_wrt_en) begin
        if (wbq.size() == 0) chk("wb_unexpected", int'(wb_addrD), 99);
        else chk("wb_addr", int'(wb_addrD), int'(wbq.pop_front()));
      end
    end
  end

  task automatic issue(input logic v, input int ra, input logic ua, input int rb,
                       input logic ub, input int rd, input logic wr, input logic ld,
                       input logic fl, input logic es, input logic [1:0] ea,
                       input logic [1:0] eb, input logic ew);
    dec_valid = v; dec_regA = 5'(ra); dec_useA = ua; dec_regB = 5'(rb);
    dec_useB = ub; dec_regD = 5'(rd); dec_writes = wr; dec_is_load = ld; flush = fl;
    #2;
    chk("stall", int'(stall), int'(es));
    if (v && !fl && !es) exq.push_back({ea, eb});
    if (ew) wbq.push_back(5'(rd));
    @(posedge clk); #1;
    if (es || fl) chk("bubble_ex_valid", int'(ex_valid), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_fwdA"}, int'(fwdA_sel), 0);
    chk({tag, "_fwdB"}, int'(fwdB_sel), 0);
    chk({tag, "_ex_valid"}, int'(ex_valid), 0);
    chk({tag, "_wb_wrt_en"}, int'(wb_wrt_en), 0);
    chk({tag, "_wb_addrD"}, int'(wb_addrD), 0);
    chk({tag, "_stall_cnt"}, int'(stall_cnt), 0);
    chk({tag, "_fwd_cnt"}, int'(fwd_cnt), 0);
  endtask

  initial begin
    reset = 1'b1;
    dec_valid = 0; dec_regA = 0; dec_regB = 0; dec_regD = 0; dec_useA = 0;
    dec_useB = 0; dec_writes = 0; dec_is_load = 0; flush = 0;
    #12;
    chk_reset_state("por");
    @(posedge clk); #1;
    reset = 1'b0;

    // ALU chain: add r3<-r1,r2 ; sub r4<-r3,r5
    issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    issue(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 2'b01, 2'b00, 1);
    idle(3);
    chk("alu_fwd_cnt", int'(fwd_cnt), 1);
    chk("alu_stall_cnt", int'(stall_cnt), 0);

    // Distance-2, r0 producer, immediate operand, newest-producer priority
    issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    issue(1, 3, 1, 3, 1, 6, 1, 0, 0, 0, 2'b10, 2'b10, 1);
    issue(1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    issue(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    issue(1, 1, 1, 1, 1, 12, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    issue(1, 12, 1, 12, 0, 13, 1, 0, 0, 0, 2'b01, 2'b00, 1);
    issue(1, 13, 1, 12, 1, 14, 1, 0, 0, 0, 2'b01, 2'b10, 1);
    issue(1, 1, 1, 1, 1, 16, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    issue(1, 16, 1, 1, 1, 16, 1, 0, 0, 0, 2'b01, 2'b00, 1);
    issue(1, 16, 1, 16, 1, 17, 1, 0, 0, 0, 2'b01, 2'b01, 1);
    idle(3);
    chk("fwd_cnt_mix", int'(fwd_cnt), 6);

    // Load-use: lw r7 ; add r8<-r7,r1
    issue(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1);
    issue(1, 7, 1, 1, 1, 8, 1, 0, 0, 1, 2'b00, 2'b00, 0);
    issue(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 2'b10, 2'b00, 1);
    idle(3);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    chk("lu_fwd_cnt", int'(fwd_cnt), 7);

    // Flush while the load-use stall would fire: both instructions squashed
    issue(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    issue(1, 7, 1, 1, 1, 8, 1, 0, 1, 0, 2'b00, 2'b00, 0);
    idle(4);
    chk("flush_stall_cnt", int'(stall_cnt), 1);

    // Reset asserted mid-stall
    issue(1, 1, 1, 1, 1, 20, 1, 0, 0, 0, 2'b00, 2'b00, 1);
    issue(1, 1, 1, 1, 1, 21, 1, 0, 0, 0, 2'b00, 2'b00, 0);
    issue(1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    dec_valid = 1; dec_regA = 7; dec_useA = 1; dec_regB = 1; dec_useB = 1;
    dec_regD = 8; dec_writes = 1; dec_is_load = 0; flush = 0;
    #1;
    chk("pre_reset_stall", int'(stall), 1);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    chk_reset_state("mid");
    @(posedge clk); #1;
    dec_valid = 0;
    reset = 1'b0;

    // Saturation on the 4-bit counter instance
    issue(1, 7, 1, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00, 1);
    for (int i = 1; i <= 16; i++) begin
      issue(1, 7, 1, 0, 0, 7, 1, 1, 0, 1, 2'b00, 2'b00, 0);
      if (i == 15) chk("sat_at_max", int'(s_stall_cnt), 15);
      if (i == 16) chk("sat_hold", int'(s_stall_cnt), 15);
      issue(1, 7, 1, 0, 0, 7, 1, 1, 0, 0, 2'b10, 2'b00, 1);
    end
    idle(4);
    chk("sat_fwd_hold", int'(s_fwd_cnt), 15);
    chk("main_stall_cnt", int'(stall_cnt), 16);
    chk("main_fwd_cnt", int'(fwd_cnt), 16);
    chk("exq_drained", exq.size(), 0);
    chk("wbq_drained", wbq.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
